fft_r2sdf_bf_stage4: RTL and testbench
======================================

# fft_r2sdf_bf_stage4

Radix-2 single-path delay-feedback (R2SDF) butterfly stage for the delay-4 stage (stage 3 of 5) of the 32-point FFT datapath. The 4-deep delay line `shift_4` sits in this stage's feedback loop. This block feeds it through `sr_din_*`/`sr_in_valid` and consumes its output through `sr_dout_*`. It performs the add/subtract butterfly, applies the W8^k twiddle to difference outputs, and emits a registered stream with `out_valid` to the delay-2 stage.

## Interface
- `DW`, 24: sample component width, two's complement.
- `TW_C`, 181: Q0.`TW_FRAC` approximation of 1/√2.
- `TW_FRAC`, 8: fractional bits of `TW_C`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  sample valid; contiguous for each 32-sample frame.
- `din_r`, `din_i`  in  DW  input sample.
- `sr_dout_r`, `sr_dout_i`  in  DW  delay-line output (sample pushed 4 pushes earlier).
- `sr_in_valid`  out  1  delay-line push enable, combinational.
- `sr_din_r`, `sr_din_i`  out  DW  delay-line input, combinational.
- `out_valid`  out  1  registered output valid.
- `dout_r`, `dout_i`  out  DW  registered output sample.

## Operation
- **State:**
  - `cnt[2:0]`: mod-8 counter. `cnt[2]` is the phase; `k = cnt[1:0]`.
  - `primed` flag.
  - `drain[2:0]` counter.
  - FSM states: IDLE, RUN, DRAIN.
- **IDLE:**
  - `sr_in_valid = 0`. `sr_din = 0`. `cnt` holds 0.
  - `in_valid = 1` → enter RUN, processing that sample as phase A with `cnt = 0`.
- **RUN**, on each cycle with `in_valid = 1`, `cnt` increments (wraps 7→0):
  - **Phase A** (`cnt[2] = 0`):
    - `sr_din = din`.
    - Computed output is the twiddle of `sr_dout`, with index `k`.
    - Output is marked valid only if `primed = 1`.
  - **Phase B** (`cnt[2] = 1`):
    - Computed output is `sr_dout + din`.
    - `sr_din = sr_dout − din`.
    - Output is always marked valid.
    - Sets `primed`.
  - `sr_in_valid = 1` throughout RUN.
- **Leaving RUN:**
  - `in_valid = 0` with `cnt = 0` and `primed = 1` → enter DRAIN.
  - `in_valid = 0` with `primed = 0` → enter IDLE.
  - `in_valid = 0` mid-frame (`cnt ≠ 0`) is a protocol error. The block enters DRAIN anyway, `cnt` continues, and `din` is treated as 0.
- **DRAIN:**
  - Runs 4 cycles as phase A with `din = 0`, `sr_din = 0`, `sr_in_valid = 1`, emitting the twiddled differences.
  - Then clears `primed` and enters IDLE.
  - `in_valid = 1` during DRAIN starts a new frame immediately: that sample is phase A with `cnt` continuing and DRAIN is abandoned. Output remains valid because `primed` stays 1.
- **Twiddle** on `(a, b) = sr_dout`, with sums formed at DW+1 bits and `m(x) = (x·TW_C) >>> TW_FRAC` (arithmetic shift, floor):
  - k=0: `(a, b)`
  - k=1: `(m(a+b), m(b−a))`
  - k=2: `(b, −a)`
  - k=3: `(m(b−a), m(−a−b))`
- **Width rules:**
  - Butterfly sum/difference are truncated modulo 2^DW, with no saturation; upstream scaling guarantees headroom.
  - Twiddle results are truncated to DW.
- **Reset:**
  - Clears `cnt`, `primed`, `drain`, and the FSM (→ IDLE), `out_valid`, and `dout_r`/`dout_i` to 0.
  - Reset mid-frame discards the frame. The shared reset also clears the delay line.

## Timing
- Latency: a sample computed in cycle t appears on `dout` and `out_valid` at edge t+1.
- Frame timing, with first sample x0 accepted in cycle 0 and a single frame:
  - `out_valid` is high in cycles 5–12 (8 cycles) per 8 input samples.
  - Outputs are sums for cycles 5–8, then twiddled differences for cycles 9–12.
- Back-to-back frames: `out_valid` stays continuously high from cycle 5 until 4 cycles after the last sample's phase B output.
- `sr_din`/`sr_in_valid` are combinational from `din`, `sr_dout`, and state; there is no pipeline register in the feedback loop.
- All outputs are 0 in IDLE and after reset.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid = 1` → `out_valid = 0`, `dout = 0`, `sr_in_valid = 0` during reset and the cycle after.
- **Single frame:** x0..x7 = (100,0),(200,0)…(800,0) from cycle 0.
  - `dout` in cycles 5–8 = (600,0),(800,0),(1000,0),(1200,0).
  - Cycles 9–12 = (−400,0),(−283,282),(0,400),(282,282).
  - `out_valid` is low at cycle 13.
- **Back-to-back frames:** two frames of the above with no gap → `out_valid` is unbroken in cycles 5–20. The second frame's sums are (600,0)… at cycles 13–16, interleaved correctly after the first frame's differences.
- **Overflow wrap:** x0 = (0x7FFFFF,0), x4 = (1,0) → sum output = (0x800000,0), difference output at k=0 = (0x7FFFFE,0).
- **Imaginary/twiddle path:** all samples (0,256) → sums (0,512). Differences are 0, so twiddled outputs are (0,0), with correct sign handling at k=2 (0,0).
- **Mid-frame reset:** reset at cycle 6 → all outputs are 0 next cycle. A fresh frame starting at cycle 10 reproduces the single-frame results offset by 10 cycles.

Source files
------------

// File: rtl/fft_r2sdf_bf_stage4.sv
// ---------------------------------------------------------------------------
// fft_r2sdf_bf_stage4 : R2SDF butterfly for the delay-4 stage of the 32-pt FFT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_r2sdf_bf_stage4 #(
   parameter int DW      = 24,
   parameter int TW_C    = 181,
   parameter int TW_FRAC = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] din_r,
   input  logic signed [DW-1:0] din_i,
   input  logic signed [DW-1:0] sr_dout_r,
   input  logic signed [DW-1:0] sr_dout_i,
   output logic                 sr_in_valid,
   output logic signed [DW-1:0] sr_din_r,
   output logic signed [DW-1:0] sr_din_i,
   output logic                 out_valid,
   output logic signed [DW-1:0] dout_r,
   output logic signed [DW-1:0] dout_i
);

   localparam int PW = DW + TW_FRAC + 2;
   localparam logic signed [TW_FRAC:0] TW_COEF = (TW_FRAC+1)'(TW_C);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [2:0]           drain_q, drain_d;
   logic                 primed_q, primed_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [DW-1:0] dout_r_q, dout_r_d;
   logic signed [DW-1:0] dout_i_q, dout_i_d;

   logic                 take, flush;
   logic signed [DW-1:0] x_r, x_i;
   logic signed [DW:0]   a_x, b_x, ab_sum, ba_dif, ab_neg;
   logic signed [DW-1:0] a_neg;
   logic signed [DW-1:0] tw_r, tw_i;

   function automatic logic signed [DW-1:0] tw_mul(input logic signed [DW:0] x);
      logic signed [PW-1:0] prod;
      prod = PW'(x) * PW'(TW_COEF);
      prod = prod >>> TW_FRAC;
      return prod[DW-1:0];
   endfunction

   // W8^k rotation of the delay-line output, indexed by the low counter bits
   always_comb begin
      a_x    = {sr_dout_r[DW-1], sr_dout_r};
      b_x    = {sr_dout_i[DW-1], sr_dout_i};
      ab_sum = a_x + b_x;
      ba_dif = b_x - a_x;
      ab_neg = -a_x - b_x;
      a_neg  = -sr_dout_r;
      tw_r   = sr_dout_r;
      tw_i   = sr_dout_i;
      case (cnt_q[1:0])
         2'd0: begin
            tw_r = sr_dout_r;
            tw_i = sr_dout_i;
         end
         2'd1: begin
            tw_r = tw_mul(ab_sum);
            tw_i = tw_mul(ba_dif);
         end
         2'd2: begin
            tw_r = sr_dout_i;
            tw_i = a_neg;
         end
         default: begin
            tw_r = tw_mul(ba_dif);
            tw_i = tw_mul(ab_neg);
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      primed_d    = primed_q;
      take        = 1'b0;
      flush       = 1'b0;
      sr_in_valid = 1'b0;
      sr_din_r    = '0;
      sr_din_i    = '0;
      out_valid_d = 1'b0;
      dout_r_d    = '0;
      dout_i_d    = '0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               take    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sr_in_valid = 1'b1;
            if (in_valid) begin
               take = 1'b1;
            end else if (primed_q) begin
               flush   = 1'b1;
               state_d = S_DRAIN;
               drain_d = 3'd1;
               cnt_d   = cnt_q + 3'd1;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (in_valid) begin
               take    = 1'b1;
               state_d = S_RUN;
               drain_d = '0;
            end else begin
               flush = 1'b1;
               if (drain_q == 3'd3) begin
                  state_d  = S_IDLE;
                  primed_d = 1'b0;
                  cnt_d    = '0;
                  drain_d  = '0;
               end else begin
                  drain_d = drain_q + 3'd1;
                  cnt_d   = cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Drain cycles run the same datapath with a zero input sample
      x_r = take ? din_r : '0;
      x_i = take ? din_i : '0;

      if (take) begin
         cnt_d = cnt_q + 3'd1;
      end

      if (take || flush) begin
         sr_in_valid = 1'b1;
         if (!cnt_q[2]) begin
            sr_din_r = x_r;
            sr_din_i = x_i;
            if (primed_q) begin
               out_valid_d = 1'b1;
               dout_r_d    = tw_r;
               dout_i_d    = tw_i;
            end
         end else begin
            sr_din_r    = sr_dout_r - x_r;
            sr_din_i    = sr_dout_i - x_i;
            dout_r_d    = sr_dout_r + x_r;
            dout_i_d    = sr_dout_i + x_i;
            out_valid_d = 1'b1;
            if (take) begin
               primed_d = 1'b1;
            end
         end
      end

      if (reset) begin
         sr_in_valid = 1'b0;
         sr_din_r    = '0;
         sr_din_i    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         drain_q     <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         dout_r_q    <= '0;
         dout_i_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         dout_r_q    <= dout_r_d;
         dout_i_q    <= dout_i_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout_r    = dout_r_q;
   assign dout_i    = dout_i_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_r2sdf_bf_stage4.sv
// ---------------------------------------------------------------------------
// tb_fft_r2sdf_bf_stage4 : scoreboard bench with a 4-deep delay-line model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_r2sdf_bf_stage4;

   localparam int DW = 24;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic signed [DW-1:0] din_r, din_i;
   logic signed [DW-1:0] sr_dout_r, sr_dout_i;
   logic                 sr_in_valid;
   logic signed [DW-1:0] sr_din_r, sr_din_i;
   logic                 out_valid;
   logic signed [DW-1:0] dout_r, dout_i;

   always #5 clk = ~clk;

   fft_r2sdf_bf_stage4 #(.DW(DW), .TW_C(181), .TW_FRAC(8)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .din_r      (din_r),
      .din_i      (din_i),
      .sr_dout_r  (sr_dout_r),
      .sr_dout_i  (sr_dout_i),
      .sr_in_valid(sr_in_valid),
      .sr_din_r   (sr_din_r),
      .sr_din_i   (sr_din_i),
      .out_valid  (out_valid),
      .dout_r     (dout_r),
      .dout_i     (dout_i)
   );

   // shift_4 delay line: output is the sample pushed four pushes earlier
   logic signed [DW-1:0] dl_r [4];
   logic signed [DW-1:0] dl_i [4];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            dl_r[i] <= '0;
            dl_i[i] <= '0;
         end
      end else if (sr_in_valid) begin
         dl_r[0] <= sr_din_r;
         dl_i[0] <= sr_din_i;
         for (int i = 1; i < 4; i++) begin
            dl_r[i] <= dl_r[i-1];
            dl_i[i] <= dl_i[i-1];
         end
      end
   end

   assign sr_dout_r = dl_r[3];
   assign sr_dout_i = dl_i[3];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   logic signed [DW-1:0] q_r [$];
   logic signed [DW-1:0] q_i [$];
   logic signed [DW-1:0] e_r, e_i;

   task automatic push_exp(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
      q_r.push_back(r);
      q_i.push_back(i);
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         chk("sb_nonempty", longint'(q_r.size() > 0), 1);
         if (q_r.size() > 0) begin
            e_r = q_r.pop_front();
            e_i = q_i.pop_front();
            chk("dout_r", dout_r, e_r);
            chk("dout_i", dout_i, e_i);
         end
      end
   end

   // Stimulus tables, indexed by cycle within one run
   logic                 iv_t [64];
   logic                 rs_t [64];
   logic signed [DW-1:0] xr_t [64];
   logic signed [DW-1:0] xi_t [64];
   int vl0, vh0, vl1, vh1, sl0, sh0, sl1, sh1, zl, zh;

   task automatic clear_tab();
      for (int c = 0; c < 64; c++) begin
         iv_t[c] = 1'b0;
         rs_t[c] = 1'b0;
         xr_t[c] = '0;
         xi_t[c] = '0;
      end
   endtask

   task automatic set_win(input int a, b, c, d, e, f, g, h, i, j);
      vl0 = a; vh0 = b; vl1 = c; vh1 = d;
      sl0 = e; sh0 = f; sl1 = g; sh1 = h;
      zl  = i; zh  = j;
   endtask

   function automatic bit inr(input int x, input int lo, input int hi);
      return (x >= lo) && (x <= hi);
   endfunction

   function automatic longint mm(input longint x);
      return (x * 181) >>> 8;
   endfunction

   // Reference frame result: four sums, then W8^k-rotated differences
   task automatic push_frame(input int base);
      logic signed [DW-1:0] r, i;
      longint a, b;
      for (int k = 0; k < 4; k++) begin
         r = xr_t[base+k] + xr_t[base+k+4];
         i = xi_t[base+k] + xi_t[base+k+4];
         push_exp(r, i);
      end
      for (int k = 0; k < 4; k++) begin
         r = xr_t[base+k] - xr_t[base+k+4];
         i = xi_t[base+k] - xi_t[base+k+4];
         a = r;
         b = i;
         case (k)
            0: push_exp(DW'(a), DW'(b));
            1: push_exp(DW'(mm(a + b)), DW'(mm(b - a)));
            2: push_exp(DW'(b), DW'(-a));
            default: push_exp(DW'(mm(b - a)), DW'(mm(-a - b)));
         endcase
      end
   endtask

   task automatic push_single_const();
      push_exp(600, 0);  push_exp(800, 0);  push_exp(1000, 0); push_exp(1200, 0);
      push_exp(-400, 0); push_exp(-283, 282); push_exp(0, 400); push_exp(282, 282);
   endtask

   task automatic run_seq(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         reset    = rs_t[c];
         in_valid = iv_t[c];
         din_r    = xr_t[c];
         din_i    = xi_t[c];
         #1;
         chk("sr_in_valid", sr_in_valid, longint'(inr(c, sl0, sh0) || inr(c, sl1, sh1)));
         if (rs_t[c]) begin
            chk("sr_din_r_rst", sr_din_r, 0);
            chk("sr_din_i_rst", sr_din_i, 0);
         end
         @(posedge clk);
         #1;
         chk("out_valid", out_valid, longint'(inr(c+1, vl0, vh0) || inr(c+1, vl1, vh1)));
         if (inr(c+1, zl, zh)) begin
            chk("dout_r_zero", dout_r, 0);
            chk("dout_i_zero", dout_i, 0);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      din_r    = '0;
      din_i    = '0;

      // Reset held two cycles with in_valid high
      clear_tab();
      rs_t[0] = 1'b1; rs_t[1] = 1'b1;
      iv_t[0] = 1'b1; iv_t[1] = 1'b1;
      xr_t[0] = 5;    xr_t[1] = 7;
      set_win(1, 0, 1, 0, 1, 0, 1, 0, 1, 4);
      run_seq(4);

      // Single frame 100..800
      clear_tab();
      for (int k = 0; k < 8; k++) begin
         iv_t[k] = 1'b1;
         xr_t[k] = DW'(100 * (k + 1));
      end
      push_single_const();
      set_win(5, 12, 1, 0, 0, 11, 1, 0, 13, 14);
      run_seq(14);

      // Two frames back to back
      clear_tab();
      for (int k = 0; k < 16; k++) begin
         iv_t[k] = 1'b1;
         xr_t[k] = DW'(100 * ((k % 8) + 1));
      end
      push_frame(0);
      push_frame(8);
      set_win(5, 20, 1, 0, 0, 19, 1, 0, 21, 22);
      run_seq(22);

      // Modulo-2^DW wrap of the butterfly
      clear_tab();
      for (int k = 0; k < 8; k++) iv_t[k] = 1'b1;
      xr_t[0] = 24'sh7FFFFF;
      xr_t[4] = 1;
      push_exp(24'sh800000, 0); push_exp(0, 0); push_exp(0, 0); push_exp(0, 0);
      push_exp(24'sh7FFFFE, 0); push_exp(0, 0); push_exp(0, 0); push_exp(0, 0);
      set_win(5, 12, 1, 0, 0, 11, 1, 0, 13, 14);
      run_seq(14);

      // Imaginary-only samples
      clear_tab();
      for (int k = 0; k < 8; k++) begin
         iv_t[k] = 1'b1;
         xi_t[k] = 256;
      end
      for (int k = 0; k < 4; k++) push_exp(0, 512);
      for (int k = 0; k < 4; k++) push_exp(0, 0);
      set_win(5, 12, 1, 0, 0, 11, 1, 0, 13, 14);
      run_seq(14);

      // Random complex frame exercising all twiddles with mixed signs
      clear_tab();
      for (int k = 0; k < 8; k++) begin
         iv_t[k] = 1'b1;
         xr_t[k] = DW'(int'($urandom_range(0, 2097151)) - 1048576);
         xi_t[k] = DW'(int'($urandom_range(0, 2097151)) - 1048576);
      end
      push_frame(0);
      set_win(5, 12, 1, 0, 0, 11, 1, 0, 13, 14);
      run_seq(14);

      // Reset mid-frame at cycle 6, fresh frame at cycle 10
      clear_tab();
      for (int k = 0; k < 6; k++) begin
         iv_t[k] = 1'b1;
         xr_t[k] = DW'(100 * (k + 1));
      end
      rs_t[6] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         iv_t[10+k] = 1'b1;
         xr_t[10+k] = DW'(100 * (k + 1));
      end
      push_exp(600, 0);
      push_exp(800, 0);
      push_single_const();
      set_win(5, 6, 15, 22, 0, 5, 10, 21, 7, 9);
      run_seq(24);

      chk("sb_drained", q_r.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
